fwd_hazard_unit: RTL and testbench

Parametrised successor to the combinational two-stage forwarding unit for the pipelined MIPS core. It keeps its own DEPTH-entry shift register of in-flight destination tags (EX, MEM, WB, ...) and, from that register, generates per-operand forwarding selects for ALU A, ALU B and store data. It also generates the load-use Stall. It sits beside the ID/EX pipeline register; the datapath bypass muxes consume its selects in the same cycle.

---
 rtl/fwd_hazard_unit_if.sv | 53 +++++
 rtl/fwd_hazard_unit.sv | 125 ++++++++++++
 tb/tb_fwd_hazard_unit.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/fwd_hazard_unit_if.sv
// ============================================================================
// Module      : fwd_hazard_unit_if
// Description : ID-stage operand/control bundle and forwarding/stall results
//               for fwd_hazard_unit. Optional macro: FWD_STALL_COUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fwd_hazard_unit_if #(
  parameter int REG_ADDR_W = 5,
  parameter int DEPTH      = 3
);
  localparam int SEL_W = $clog2(DEPTH + 1);

  logic [REG_ADDR_W-1:0] ID_Rs;
  logic [REG_ADDR_W-1:0] ID_Rt;
  logic [REG_ADDR_W-1:0] ID_Rw;
  logic                  ID_RegWrite;
  logic                  ID_MemRead;
  logic                  ID_MemWrite;
  logic                  UseShamt;
  logic                  UseImmed;
  logic                  Flush;

  logic                  Stall;
  logic [SEL_W-1:0]      AluOpCtrlA;
  logic [SEL_W-1:0]      AluOpCtrlB;
  logic [SEL_W-1:0]      DataMemFwdSel;
  logic [DEPTH-1:0]      StageValid;
`ifdef FWD_STALL_COUNT_EN
  logic [31:0]           StallCount;
`endif

  modport master (
    output ID_Rs, ID_Rt, ID_Rw, ID_RegWrite, ID_MemRead, ID_MemWrite,
           UseShamt, UseImmed, Flush,
    input  Stall, AluOpCtrlA, AluOpCtrlB, DataMemFwdSel, StageValid
`ifdef FWD_STALL_COUNT_EN
    , input StallCount
`endif
  );

  modport slave (
    input  ID_Rs, ID_Rt, ID_Rw, ID_RegWrite, ID_MemRead, ID_MemWrite,
           UseShamt, UseImmed, Flush,
    output Stall, AluOpCtrlA, AluOpCtrlB, DataMemFwdSel, StageValid
`ifdef FWD_STALL_COUNT_EN
    , output StallCount
`endif
  );
endinterface

`default_nettype wire

// File: rtl/fwd_hazard_unit.sv
// ============================================================================
// Module      : fwd_hazard_unit
// Description : Tracks DEPTH in-flight destination tags and produces operand
//               forwarding selects plus the load-use stall, all combinational
//               from the tag register and the ID inputs.
//               Optional macro: FWD_STALL_COUNT_EN (adds 32-bit StallCount).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fwd_hazard_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int DEPTH      = 3,
  parameter int LOAD_LAT   = 1
) (
  input  wire logic        CLK,
  input  wire logic        Reset,
  fwd_hazard_unit_if.slave bus
);
  localparam int SEL_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic             hit;
    logic             haz;
    logic [SEL_W-1:0] sel;
  } match_t;

  // Index 0 is stage 1 (EX); index DEPTH-1 is the oldest tracked stage.
  logic [REG_ADDR_W-1:0] r_rw [DEPTH];
  logic [DEPTH-1:0]      r_wr;
  logic [DEPTH-1:0]      r_ld;

  logic [DEPTH-1:0]      w_valid;
  logic                  w_load_bubble;
  logic                  w_stall;
  logic                  w_en_a;
  logic                  w_en_b;
  logic                  w_en_d;
  match_t                w_match_rs;
  match_t                w_match_rt;

  for (genvar k = 0; k < DEPTH; k++) begin : g_valid
    assign w_valid[k] = r_wr[k] && (r_rw[k] != '0);
  end

  // Youngest valid producer wins; a not-yet-ready load blocks older producers.
  function automatic match_t f_match(input logic [REG_ADDR_W-1:0] src);
    match_t m;
    m = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (!m.hit && w_valid[k] && (r_rw[k] == src) && (src != '0)) begin
        m.hit = 1'b1;
        if (r_ld[k] && ((k + 1) <= LOAD_LAT)) begin
          m.haz = 1'b1;
        end else begin
          m.sel = SEL_W'(k + 1);
        end
      end
    end
    return m;
  endfunction

  always_comb begin
    w_match_rs = f_match(bus.ID_Rs);
    w_match_rt = f_match(bus.ID_Rt);
  end

  assign w_en_a = ~bus.UseShamt;
  assign w_en_b = ~bus.UseImmed;
  assign w_en_d = bus.ID_MemWrite;

  assign w_stall = ((w_en_a & w_match_rs.haz) |
                    (w_en_b & w_match_rt.haz) |
                    (w_en_d & w_match_rt.haz)) & ~bus.Flush & ~Reset;

  assign bus.Stall         = w_stall;
  assign bus.AluOpCtrlA    = (w_en_a && !Reset) ? w_match_rs.sel : '0;
  assign bus.AluOpCtrlB    = (w_en_b && !Reset) ? w_match_rt.sel : '0;
  assign bus.DataMemFwdSel = (w_en_d && !Reset) ? w_match_rt.sel : '0;
  assign bus.StageValid    = w_valid;

  assign w_load_bubble = w_stall | bus.Flush | ~bus.ID_RegWrite;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_rw[i] <= '0;
      end
      r_wr <= '0;
      r_ld <= '0;
    end else begin
      if (w_load_bubble) begin
        r_rw[0] <= '0;
        r_wr[0] <= 1'b0;
        r_ld[0] <= 1'b0;
      end else begin
        r_rw[0] <= bus.ID_Rw;
        r_wr[0] <= 1'b1;
        r_ld[0] <= bus.ID_MemRead;
      end
      for (int i = 1; i < DEPTH; i++) begin
        r_rw[i] <= r_rw[i-1];
        r_wr[i] <= r_wr[i-1];
        r_ld[i] <= r_ld[i-1];
      end
    end
  end

`ifdef FWD_STALL_COUNT_EN
  logic [31:0] r_stall_count;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_stall_count <= '0;
    end else if (w_stall) begin
      r_stall_count <= r_stall_count + 32'd1;
    end
  end

  assign bus.StallCount = r_stall_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fwd_hazard_unit.sv
// ============================================================================
// Module      : tb_fwd_hazard_unit
// Description : Scoreboard bench for fwd_hazard_unit with directed scenarios
//               and randomized instruction streams against a tag-list model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fwd_hazard_unit;
  localparam int REG_ADDR_W = 5;
  localparam int DEPTH      = 3;
  localparam int LOAD_LAT   = 1;

  typedef struct {
    int          rw;
    bit          wr;
    bit          ld;
  } ent_t;

  typedef struct {
    bit          stall;
    int          a;
    int          b;
    int          d;
    int          sv;
    int unsigned cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fwd_hazard_unit_if #(.REG_ADDR_W(REG_ADDR_W), .DEPTH(DEPTH)) bus ();

  fwd_hazard_unit #(
    .REG_ADDR_W(REG_ADDR_W),
    .DEPTH     (DEPTH),
    .LOAD_LAT  (LOAD_LAT)
  ) dut (
    .CLK  (clk),
    .Reset(rst),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  ent_t        pipe[$];
  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned r_cnt  = 0;
  bit          r_last_stall = 1'b0;

  // Youngest producer in the in-flight list decides; a young load is not ready.
  function automatic void model_op(input int s, output int sel, output bit haz);
    sel = 0;
    haz = 1'b0;
    if (s == 0) return;
    for (int i = 0; i < pipe.size(); i++) begin
      if (pipe[i].wr && pipe[i].rw == s) begin
        if (pipe[i].ld && (i + 1) <= LOAD_LAT) haz = 1'b1;
        else sel = i + 1;
        return;
      end
    end
  endfunction

  task automatic step(input int rs, input int rt, input int rw,
                      input bit wen, input bit mr, input bit mw,
                      input bit sh, input bit im, input bit fl, input bit rs_t);
    exp_t e;
    ent_t n;
    int   ma, mb;
    bit   ha, hb;
    @(posedge clk);
    #1;
    bus.ID_Rs       = REG_ADDR_W'(rs);
    bus.ID_Rt       = REG_ADDR_W'(rt);
    bus.ID_Rw       = REG_ADDR_W'(rw);
    bus.ID_RegWrite = wen;
    bus.ID_MemRead  = mr;
    bus.ID_MemWrite = mw;
    bus.UseShamt    = sh;
    bus.UseImmed    = im;
    bus.Flush       = fl;
    rst             = rs_t;
    model_op(rs, ma, ha);
    model_op(rt, mb, hb);
    e.a     = (sh || rs_t) ? 0 : ma;
    e.b     = (im || rs_t) ? 0 : mb;
    e.d     = (!mw || rs_t) ? 0 : mb;
    e.stall = ((!sh && ha) || (!im && hb) || (mw && hb)) && !fl && !rs_t;
    e.sv    = 0;
    for (int i = 0; i < DEPTH; i++)
      if (pipe[i].wr && pipe[i].rw != 0) e.sv |= (1 << i);
    e.cnt = r_cnt;
    sb.push_back(e);
    r_last_stall = e.stall;
    if (rs_t) begin
      r_cnt = 0;
      for (int i = 0; i < DEPTH; i++) pipe[i] = '{rw: 0, wr: 1'b0, ld: 1'b0};
    end else begin
      if (e.stall) r_cnt++;
      if (e.stall || fl || !wen) n = '{rw: 0, wr: 1'b0, ld: 1'b0};
      else                       n = '{rw: rw, wr: 1'b1, ld: mr};
      pipe.push_front(n);
      void'(pipe.pop_back());
    end
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Monitor: outputs are combinational, so one sample per cycle away from the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("stall", longint'(bus.Stall), longint'(e.stall));
        chk("selA", longint'(bus.AluOpCtrlA), e.a);
        chk("selB", longint'(bus.AluOpCtrlB), e.b);
        chk("selD", longint'(bus.DataMemFwdSel), e.d);
        chk("stage_valid", longint'(bus.StageValid), e.sv);
`ifdef FWD_STALL_COUNT_EN
        chk("stall_count", longint'(bus.StallCount), longint'(e.cnt));
`endif
      end
    end
  end

  initial begin
    int rs, rt, rw, wait_cyc;
    bit wen, mr, mw, sh, im, fl, rr;
    for (int i = 0; i < DEPTH; i++) pipe.push_back('{rw: 0, wr: 1'b0, ld: 1'b0});
    bus.ID_Rs = '0; bus.ID_Rt = '0; bus.ID_Rw = '0;
    bus.ID_RegWrite = 1'b0; bus.ID_MemRead = 1'b0; bus.ID_MemWrite = 1'b0;
    bus.UseShamt = 1'b0; bus.UseImmed = 1'b0; bus.Flush = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // First cycle after reset, then an ALU chain aged 1..4.
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 2, 3, 1, 0, 0, 0, 0, 0, 0);
    repeat (4) step(3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Load-use on B: stall once, then forward from stage 2.
    step(0, 0, 5, 1, 1, 0, 0, 0, 0, 0);
    step(0, 5, 6, 1, 0, 0, 0, 0, 0, 0);
    step(0, 5, 6, 1, 0, 0, 0, 0, 0, 0);
    // Priority: young load beats older ALU result; young ALU beats older ALU.
    step(0, 0, 4, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 4, 1, 1, 0, 0, 0, 0, 0);
    step(4, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 4, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 4, 1, 0, 0, 0, 0, 0, 0);
    step(4, 4, 0, 0, 0, 0, 0, 0, 0, 0);
    // Suppression and writes to r0.
    step(0, 0, 9, 1, 0, 0, 0, 0, 0, 0);
    step(9, 0, 10, 1, 0, 0, 1, 0, 0, 0);
    step(0, 10, 0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    // Store data forwarding and store-data load-use.
    step(0, 0, 7, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 7, 0, 0, 0, 1, 0, 1, 0, 0);
    step(0, 0, 7, 1, 1, 0, 0, 0, 0, 0);
    step(1, 7, 0, 0, 0, 1, 0, 1, 0, 0);
    // Flush during hazard, then reset mid-stall.
    step(0, 0, 8, 1, 1, 0, 0, 0, 0, 0);
    step(8, 0, 11, 1, 0, 0, 0, 0, 1, 0);
    step(0, 0, 8, 1, 1, 0, 0, 0, 0, 0);
    step(8, 0, 11, 1, 0, 0, 0, 0, 0, 0);
    step(8, 0, 11, 1, 0, 0, 0, 0, 0, 1);
    step(8, 0, 11, 1, 0, 0, 0, 0, 0, 0);

    // Random streams over a small register set to force frequent matches.
    rs = 0; rt = 0; rw = 0; wen = 0; mr = 0; mw = 0; sh = 0; im = 0;
    for (int n = 0; n < 800; n++) begin
      if (!(r_last_stall && $urandom_range(0, 3) != 0)) begin
        rs  = $urandom_range(0, 7);
        rt  = $urandom_range(0, 7);
        rw  = $urandom_range(0, 7);
        wen = ($urandom_range(0, 3) != 0);
        mr  = ($urandom_range(0, 2) == 0);
        mw  = ($urandom_range(0, 4) == 0);
        sh  = ($urandom_range(0, 5) == 0);
        im  = ($urandom_range(0, 3) == 0);
      end
      fl = ($urandom_range(0, 9) == 0);
      rr = ($urandom_range(0, 63) == 0);
      step(rs, rt, rw, wen, mr, mw, sh, im, fl, rr);
    end

    wait_cyc = 0;
    while (sb.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    repeat (2) @(posedge clk);
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
